// File: rtl/fp64_mult_checker_if.sv
// Vector-memory read port and multiplier operand/result bus seen by fp64_mult_checker.
interface fp64_mult_checker_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] vec_addr;
  logic [63:0]       vec_a;
  logic [63:0]       vec_b;
  logic [63:0]       vec_exp;
  logic [63:0]       mul_a;
  logic [63:0]       mul_b;
  logic [63:0]       mul_c;

  modport master (
    output vec_addr, mul_a, mul_b,
    input  vec_a, vec_b, vec_exp, mul_c
  );

  modport slave (
    input  vec_addr, mul_a, mul_b,
    output vec_a, vec_b, vec_exp, mul_c
  );
endinterface

// File: rtl/fp64_mult_checker.sv
// Drives {a,b} vectors into a pipelined fp64 multiplier and scores its results
// against the stored expected products; reports error count, first failing index and pass.
module fp64_mult_checker #(
  parameter int unsigned NUM_VEC = 20,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned NAN_EQ  = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  fp64_mult_checker_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_idx
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
  logic [63:0]         mul_a_q, mul_a_d;
  logic [63:0]         mul_b_q, mul_b_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  // Stage 0 travels with mul_a/mul_b; stage LATENCY lines up with mul_c.
  logic [LATENCY:0]    pv_q, pv_d;
  logic [63:0]         pe_q [LATENCY+1];
  logic [63:0]         pe_d [LATENCY+1];
  logic [ADDR_W-1:0]   pi_q [LATENCY+1];
  logic [ADDR_W-1:0]   pi_d [LATENCY+1];

  logic c_nan, e_nan, match_c;

  always_comb begin
    c_nan   = (bus.mul_c[62:52] == 11'h7FF) && (bus.mul_c[51:0] != 52'd0);
    e_nan   = (pe_q[LATENCY][62:52] == 11'h7FF) && (pe_q[LATENCY][51:0] != 52'd0);
    match_c = (bus.mul_c == pe_q[LATENCY]) || ((NAN_EQ != 0) && c_nan && e_nan);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_vld_d = 1'b0;
    rd_idx_d = rd_idx_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    err_d    = err_q;
    first_d  = first_q;

    pv_d     = {pv_q[LATENCY-1:0], rd_vld_q};
    pe_d[0]  = bus.vec_exp;
    pi_d[0]  = rd_idx_q;
    for (int unsigned i = 1; i <= LATENCY; i++) begin
      pe_d[i] = pe_q[i-1];
      pi_d[i] = pi_q[i-1];
    end

    if (rd_vld_q) begin
      mul_a_d = bus.vec_a;
      mul_b_d = bus.vec_b;
    end

    if (pv_q[LATENCY] && !match_c) begin
      if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
      if (err_q == '0)      first_d = pi_q[LATENCY];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
          err_d   = '0;
          first_d = '0;
        end
      end
      S_RUN: begin
        rd_vld_d = 1'b1;
        rd_idx_d = addr_q;
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                     addr_d  = addr_q + ADDR_W'(1);
      end
      // Leave on the edge that retires the final compare.
      S_DRAIN: begin
        if (pv_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      err_q    <= '0;
      first_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      pv_q     <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        pe_q[i] <= '0;
        pi_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      err_q    <= err_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      pv_q     <= pv_d;
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        pe_q[i] <= pe_d[i];
        pi_q[i] <= pi_d[i];
      end
    end
  end

  assign bus.vec_addr  = addr_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
endmodule
